imem_loader: RTL

Boot-time instruction-memory writer for the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each word is written into instruction memory through its write port. The core is held in reset until the programmed length has been written. It sits between the host/debug byte source and the instruction memory write port, alongside the core's top level.

---
 rtl/imem_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: turns a little-endian byte stream into 32-bit instruction-memory writes and holds the core in reset until the load is complete.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte and a sticky error flag.
module imem_loader #(
   parameter int DEPTH_WORDS = 64,
   parameter int LEN_W       = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_len_words,
   input  logic             i_in_valid,
   input  logic [7:0]       i_in_byte,
   output logic             o_in_ready,
   output logic             o_imem_we,
   output logic [31:0]      o_imem_addr,
   output logic [31:0]      o_imem_wd,
   output logic             o_cpu_hold,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH_WORDS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_DONE
   } state_t;

   state_t           r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_word_idx;
   logic [1:0]       r_byte_cnt;
   logic [23:0]      r_shift;
   logic             r_in_ready;
   logic             r_imem_we;
   logic [31:0]      r_imem_addr;
   logic [31:0]      r_imem_wd;
   logic             r_cpu_hold;
   logic             r_busy;
   logic             r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]       r_csum;
   logic             r_err;
`endif

   logic             w_hs;
   logic [LEN_W-1:0] w_len_clamped;
   logic [LEN_W-1:0] w_idx_next;

   assign w_hs          = r_in_ready & i_in_valid;
   assign w_len_clamped = (i_len_words > DEPTH_L) ? DEPTH_L : i_len_words;
   assign w_idx_next    = r_word_idx + LEN_W'(1);

   // Bytes 0..2 shift in from the top so the fourth byte completes the word as {b3,b2,b1,b0}.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_word_idx  <= '0;
         r_byte_cnt  <= '0;
         r_shift     <= '0;
         r_in_ready  <= 1'b0;
         r_imem_we   <= 1'b0;
         r_imem_addr <= '0;
         r_imem_wd   <= '0;
         r_cpu_hold  <= 1'b1;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_csum      <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_len      <= w_len_clamped;
                  r_word_idx <= '0;
                  r_byte_cnt <= '0;
                  r_cpu_hold <= 1'b1;
                  r_busy     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum     <= '0;
                  r_err      <= 1'b0;
`endif
                  if (w_len_clamped == '0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state    <= S_RECV;
                     r_in_ready <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (w_hs) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ i_in_byte;
`endif
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) begin
                     r_state     <= S_WRITE;
                     r_in_ready  <= 1'b0;
                     r_imem_we   <= 1'b1;
                     r_imem_addr <= 32'({r_word_idx, 2'b00});
                     r_imem_wd   <= {i_in_byte, r_shift};
                  end else begin
                     r_shift <= {i_in_byte, r_shift[23:8]};
                  end
               end
            end
            S_WRITE: begin
               r_imem_we  <= 1'b0;
               r_word_idx <= w_idx_next;
               if (w_idx_next == r_len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  r_state    <= S_CHECK;
                  r_in_ready <= 1'b1;
`else
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
`endif
               end else begin
                  r_state    <= S_RECV;
                  r_in_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
               if (w_hs) begin
                  r_err      <= (i_in_byte != r_csum);
                  r_in_ready <= 1'b0;
                  r_state    <= S_DONE;
                  r_done     <= 1'b1;
               end
            end
`endif
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
               r_cpu_hold <= r_err;
`else
               r_cpu_hold <= 1'b0;
`endif
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_imem_we   = r_imem_we;
   assign o_imem_addr = r_imem_addr;
   assign o_imem_wd   = r_imem_wd;
   assign o_cpu_hold  = r_cpu_hold;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign o_err       = r_err;
`else
   assign o_err       = 1'b0;
`endif

endmodule
